// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointers,
// read-pointer synchroniser, full/almost-full detection, fill level and sticky overflow.
module fifo_wr_ctrl #(
  parameter  int DEPTH       = 8,
  parameter  int AFULL_LEVEL = DEPTH - 2,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_inc,
  input  logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic [ADDR_WIDTH-1:0] W_addr,
  output logic                  W_en,
  output logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_LEVEL);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] sync1_q, sync2_q;
  logic [AW:0] bn_wr_q, bn_wr_d;
  logic [AW:0] gray_wr_q, gray_wr_d;
  logic [AW:0] level_q, level_d;
  logic        afull_q, afull_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] rd_bin;
  logic        full_c;

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer
  assign full_c    = (gray_wr_q == {~sync2_q[AW:AW-1], sync2_q[AW-2:0]});
  assign W_en      = W_inc & ~full_c;
  assign rd_bin    = gray2bin(sync2_q);

  assign bn_wr_d   = bn_wr_q + {{AW{1'b0}}, W_en};
  assign gray_wr_d = bin2gray(bn_wr_d);
  assign level_d   = bn_wr_d - rd_bin;
  assign afull_d   = (level_d >= AFULL_L);
  assign ovf_d     = ovf_q | (W_inc & full_c);

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      bn_wr_q   <= '0;
      gray_wr_q <= '0;
      level_q   <= '0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= gray_rd_ptr;
      sync2_q   <= sync1_q;
      bn_wr_q   <= bn_wr_d;
      gray_wr_q <= gray_wr_d;
      level_q   <= level_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign W_addr      = bn_wr_q[AW-1:0];
  assign gray_wr_ptr = gray_wr_q;
  assign full        = full_c;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised bench for fifo_wr_ctrl against a counter-based model of FIFO occupancy.
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;

  logic       W_CLK = 1'b0;
  logic       W_RST;
  logic       W_inc;
  logic [3:0] gray_rd_ptr;
  logic [2:0] W_addr;
  logic       W_en;
  logic [3:0] gray_wr_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  fifo_wr_ctrl #(.DEPTH(DEPTH), .AFULL_LEVEL(AF)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .W_inc(W_inc), .gray_rd_ptr(gray_rd_ptr),
    .W_addr(W_addr), .W_en(W_en), .gray_wr_ptr(gray_wr_ptr), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 W_CLK = ~W_CLK;

  int n_chk = 0;
  int n_err = 0;

  // Model: total writes accepted, read pointer seen at each edge, derived flags
  int wr_cnt;
  int rd_cnt;
  int hist[$];
  int lvl_m;
  bit af_m;
  bit ovf_m;
  int max_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] gray(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  function automatic int sync_rd();
    int n;
    n = hist.size();
    return (n >= 2) ? hist[n-2] : 0;
  endfunction

  task automatic model_reset();
    wr_cnt = 0; rd_cnt = 0; lvl_m = 0; af_m = 0; ovf_m = 0;
    hist.delete();
  endtask

  // One clock cycle: drive at negedge, check mid-low-phase, advance model at posedge
  task automatic cycle(input bit inc);
    int  rs;
    bit  full_e, en_e;
    W_inc       = inc;
    gray_rd_ptr = gray(rd_cnt);
    #1;
    rs     = sync_rd();
    full_e = (((wr_cnt - rs) % 16 + 16) % 16) == DEPTH;
    en_e   = inc && !full_e;
    chk("full",        32'(full),        32'(full_e));
    chk("W_en",        32'(W_en),        32'(en_e));
    chk("W_addr",      32'(W_addr),      32'(wr_cnt % DEPTH));
    chk("gray_wr_ptr", 32'(gray_wr_ptr), 32'(gray(wr_cnt)));
    chk("wr_level",    32'(wr_level),    32'(lvl_m));
    chk("almost_full", 32'(almost_full), 32'(af_m));
    chk("overflow",    32'(overflow),    32'(ovf_m));
    @(posedge W_CLK);
    hist.push_back(rd_cnt);
    if (inc && full_e) ovf_m = 1;
    if (en_e) wr_cnt++;
    lvl_m = ((wr_cnt - rs) % 16 + 16) % 16;
    af_m  = (lvl_m >= AF);
    if (lvl_m > max_lvl) max_lvl = lvl_m;
    @(negedge W_CLK);
  endtask

  task automatic check_reset_outputs(input bit inc);
    chk("rst_W_addr",   32'(W_addr),      0);
    chk("rst_gray_wr",  32'(gray_wr_ptr), 0);
    chk("rst_full",     32'(full),        0);
    chk("rst_afull",    32'(almost_full), 0);
    chk("rst_level",    32'(wr_level),    0);
    chk("rst_overflow", 32'(overflow),    0);
    chk("rst_W_en",     32'(W_en),        32'(inc));
  endtask

  initial begin
    W_RST = 1'b1; W_inc = 1'b0; gray_rd_ptr = '0;
    model_reset();
    max_lvl = 0;
    #1;
    check_reset_outputs(1'b0);
    @(negedge W_CLK);
    @(negedge W_CLK);
    W_RST = 1'b0;

    // Fill from empty, then keep pushing into a full FIFO
    for (int i = 0; i < 8; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    cycle(1'b0);

    // One read frees a slot; full must clear two edges later
    rd_cnt = 1;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);

    // Asynchronous reset mid-operation with level 5 and a pending write
    W_RST = 1'b1; #1; W_RST = 1'b0; model_reset();
    gray_rd_ptr = '0;
    @(negedge W_CLK);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    chk("level_before_rst", 32'(wr_level), 5);
    W_inc = 1'b1;
    W_RST = 1'b1;
    #1;
    check_reset_outputs(1'b1);
    W_inc = 1'b0;
    model_reset();
    gray_rd_ptr = '0;
    #1;
    W_RST = 1'b0;
    @(negedge W_CLK);
    cycle(1'b1);

    // Streaming write/read across several pointer wraps, writer respects full
    max_lvl = 0;
    for (int i = 0; i < 60; i++) begin
      if (rd_cnt < wr_cnt && $urandom_range(0, 3) != 0) rd_cnt++;
      cycle(1'b1 && !full);
    end
    chk("stream_no_overflow", 32'(overflow), 0);
    chk("stream_max_level_le_depth", 32'(max_lvl <= DEPTH), 1);

    // Fully random traffic, overflow allowed
    for (int i = 0; i < 400; i++) begin
      if (rd_cnt < wr_cnt && $urandom_range(0, 2) == 0) rd_cnt++;
      cycle(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end

endmodule
